// File: rtl/design_21.sv
// Registered W-bit adder: a start pulse captures (a + b) mod 2^W into y,
// and valid strobes for one cycle afterwards to qualify it.
module design_21 #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         valid
);

  logic [W-1:0] r_y;
  logic         r_valid;
  logic [W-1:0] w_sum;

  // Sum truncated to W bits; the carry-out is intentionally dropped.
  assign w_sum = W'(a + b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= start;
      if (start) begin
        r_y <= w_sum;
      end
    end
  end

  assign y     = r_y;
  assign valid = r_valid;

endmodule

// File: tb/tb_design_21.sv
// Self-checking bench for design_21: randomized and directed requests
// compared every cycle against a behavioural sum/strobe model.
module tb_design_21;

  localparam int unsigned W   = 10;
  localparam int          MOD = 1 << W;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] y;
  logic         valid;

  int checks = 0;
  int errors = 0;

  int m_y = 0;
  bit m_v = 1'b0;

  design_21 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Reference: valid follows the sampled start one edge later, y latches the
  // modular sum of the operands on every start edge, reset clears both at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = 0;
      m_v = 1'b0;
    end else begin
      m_v = start;
      if (start) m_y = (int'(a) + int'(b)) % MOD;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (valid !== m_v || y !== W'(m_y)) begin
      errors++;
      $display("FAIL model t=%0t valid=%0b y=%0d required valid=%0b y=%0d",
               $time, valid, y, m_v, m_y);
    end
  end

  task automatic lit(input string name, input bit ev, input int ey);
    checks++;
    if (valid !== ev || y !== W'(ey)) begin
      errors++;
      $display("FAIL %s valid=%0b y=%0d required valid=%0b y=%0d",
               name, valid, y, ev, ey);
    end
  endtask

  // Drive one cycle of inputs; returns just after the following negedge.
  task automatic step(input bit s, input int av, input int bv);
    start = s;
    a     = W'(av);
    b     = W'(bv);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 lit("reset_async", 1'b0, 0);
    @(negedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      step(bit'(i % 2 == 0), 100 + i, 200 + i);
      lit("reset_hold", 1'b0, 0);
    end

    start = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 0, 0);
    lit("post_reset_idle0", 1'b0, 0);
    step(1'b0, 55, 66);
    lit("post_reset_idle1", 1'b0, 0);

    step(1'b1, 100, 23);
    lit("basic_sum", 1'b1, 123);
    step(1'b0, 7, 9);
    lit("basic_hold", 1'b0, 123);

    step(1'b1, 1023, 1);
    lit("wrap_zero", 1'b1, 0);
    step(1'b1, 1023, 1023);
    lit("wrap_max", 1'b1, 1022);

    step(1'b0, 0, 0);
    step(1'b1, 5, 6);
    lit("b2b_first", 1'b1, 11);
    step(1'b1, 700, 400);
    lit("b2b_second", 1'b1, 76);
    step(1'b0, 0, 0);
    lit("b2b_done", 1'b0, 76);

    // Reset lands between the start edge and the next clock.
    start = 1'b1;
    a     = W'(3);
    b     = W'(4);
    @(posedge clk);
    #1;
    lit("mid_before_reset", 1'b1, 7);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    lit("mid_reset_drop", 1'b0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 0, 0);
    lit("mid_no_pulse0", 1'b0, 0);
    step(1'b0, 0, 0);
    lit("mid_no_pulse1", 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(MOD - 1, 0));
      rb = int'($urandom_range(MOD - 1, 0));
      step(1'b1, ra, rb);
      step(1'b0, int'($urandom_range(MOD - 1, 0)), int'($urandom_range(MOD - 1, 0)));
      step(1'b0, 0, 0);
    end

    for (int i = 0; i < 40; i++) begin
      step(bit'($urandom_range(1, 0)), int'($urandom_range(MOD - 1, 0)),
           int'($urandom_range(MOD - 1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
